// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU destination-register path.
//   REG_IDX_W      : architectural register-index width
//   dst_sel_e      : candidate-select encodings (rt, rd, return-address reg 31)
//   onehot_lowest  : isolates the lowest set bit of a vector (up to 32 bits)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int REG_IDX_W = 5;

  // Values driven on the destination-select input.
  typedef enum logic [1:0] {
    SEL_RT = 2'd0,
    SEL_RD = 2'd1,
    SEL_RA = 2'd2
  } dst_sel_e;

  // Two's-complement trick: v & -v keeps only the least significant set bit.
  // Callers zero-extend narrower vectors and truncate the result back.
  function automatic logic [31:0] onehot_lowest(input logic [31:0] vec);
    return vec & (~vec + 32'd1);
  endfunction

endpackage

// File: rtl/dest_match.sv
// -----------------------------------------------------------------------------
// dest_match
// Compares one source register against every in-flight destination and
// reports the youngest (lowest-index) valid match.
//   stage_dst_i : flattened per-stage destinations, stage k at [k*WIDTH +: WIDTH]
//   stage_vld_i : per-stage valid bits
//   src_i       : source register index to look up
//   hit_o       : any stage matches
//   hit_stg_o   : one-hot lowest matching stage, zero when none
// -----------------------------------------------------------------------------
module dest_match
  import cpu_pkg::*;
#(
  parameter int WIDTH        = REG_IDX_W,
  parameter int STAGES       = 3,
  parameter bit ZERO_IS_NULL = 1'b1
) (
  input  logic [STAGES*WIDTH-1:0] stage_dst_i,
  input  logic [STAGES-1:0]       stage_vld_i,
  input  logic [WIDTH-1:0]        src_i,
  output logic                    hit_o,
  output logic [STAGES-1:0]       hit_stg_o
);

  logic [STAGES-1:0] match;

  always_comb begin
    match = '0;
    for (int k = 0; k < STAGES; k++) begin
      match[k] = stage_vld_i[k] && (stage_dst_i[k*WIDTH +: WIDTH] == src_i);
    end
    // Register 0 is a "no write" sink, so reading it never depends on anything.
    if (ZERO_IS_NULL && (src_i == '0)) begin
      match = '0;
    end
  end

  assign hit_o     = |match;
  assign hit_stg_o = STAGES'(onehot_lowest(32'(match)));

endmodule

// File: rtl/dest_sel_pipe.sv
// -----------------------------------------------------------------------------
// dest_sel_pipe
// Selects the destination register of the decoding instruction from NUM_IN
// candidates and carries it, with a write-valid bit, through STAGES pipeline
// registers (stage 0 youngest, stage STAGES-1 = write-back).
//   clk, rst_n          : clock, asynchronous active-low reset
//   sel, cand           : candidate select / flattened candidates
//   in_valid            : entering instruction writes a register
//   stall, flush        : freeze all stages / kill the FLUSH_STAGES youngest
//   src_a, src_b        : sources of the decoding instruction
//   stage_dst/stage_vld : per-stage destination and valid
//   wb_dst, wb_en       : register-file write port (last stage)
//   hazard_*            : source matches a valid in-flight destination
//   sel_err             : registered one-cycle pulse for an out-of-range select
//
// Valid semantics: stage_vld[k] = 1 means the instruction in stage k will
// write stage_dst[k]; there is no back-pressure other than stall, which
// freezes every stage, and flush, which only clears valid bits.
// -----------------------------------------------------------------------------
module dest_sel_pipe
  import cpu_pkg::*;
#(
  parameter int WIDTH        = REG_IDX_W,
  parameter int NUM_IN       = 3,
  parameter int SEL_W        = 2,
  parameter int STAGES       = 3,
  parameter int FLUSH_STAGES = 2,
  parameter bit ZERO_IS_NULL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] cand,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        src_a,
  input  logic [WIDTH-1:0]        src_b,
  output logic [STAGES*WIDTH-1:0] stage_dst,
  output logic [STAGES-1:0]       stage_vld,
  output logic [WIDTH-1:0]        wb_dst,
  output logic                    wb_en,
  output logic                    hazard_a,
  output logic [STAGES-1:0]       hazard_a_stg,
  output logic                    hazard_b,
  output logic [STAGES-1:0]       hazard_b_stg,
  output logic                    sel_err
);

  logic [STAGES-1:0][WIDTH-1:0] dst_q, dst_d;
  logic [STAGES-1:0]            vld_q, vld_d;
  logic                         sel_err_q, sel_err_d;

  logic                         sel_legal;
  logic [WIDTH-1:0]             cand_sel;

  // Candidate mux; an out-of-range select yields 0 but is never loaded.
  always_comb begin
    sel_legal = (32'(sel) < NUM_IN);
    cand_sel  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        cand_sel = cand[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    dst_d     = dst_q;
    vld_d     = vld_q;
    sel_err_d = 1'b0;

    if (!stall) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        dst_d[k] = dst_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
      if (sel_legal) begin
        dst_d[0] = cand_sel;
        vld_d[0] = in_valid && !(ZERO_IS_NULL && (cand_sel == '0));
      end else begin
        // Explicit hold of dst0 with a bubble instead of a latch.
        vld_d[0]  = 1'b0;
        sel_err_d = 1'b1;
      end
    end

    // Flush overrides stall for the youngest stages; dst is left as loaded/held.
    if (flush) begin
      for (int k = 0; k < FLUSH_STAGES; k++) begin
        vld_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q     <= '0;
      vld_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      dst_q     <= dst_d;
      vld_q     <= vld_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign stage_dst = dst_q;
  assign stage_vld = vld_q;
  assign wb_dst    = dst_q[STAGES-1];
  assign wb_en     = vld_q[STAGES-1];
  assign sel_err   = sel_err_q;

  dest_match #(
    .WIDTH        (WIDTH),
    .STAGES       (STAGES),
    .ZERO_IS_NULL (ZERO_IS_NULL)
  ) u_match_a (
    .stage_dst_i (stage_dst),
    .stage_vld_i (stage_vld),
    .src_i       (src_a),
    .hit_o       (hazard_a),
    .hit_stg_o   (hazard_a_stg)
  );

  dest_match #(
    .WIDTH        (WIDTH),
    .STAGES       (STAGES),
    .ZERO_IS_NULL (ZERO_IS_NULL)
  ) u_match_b (
    .stage_dst_i (stage_dst),
    .stage_vld_i (stage_vld),
    .src_i       (src_b),
    .hit_o       (hazard_b),
    .hit_stg_o   (hazard_b_stg)
  );

endmodule

// File: tb/tb_dest_sel_pipe.sv
// -----------------------------------------------------------------------------
// tb_dest_sel_pipe
// Two instances: default parameters (u1) and a wider/deeper sweep (u2,
// WIDTH=6, NUM_IN=4, STAGES=5, FLUSH_STAGES=1). Both see the same control
// stimulus. A reference model of each pipeline predicts a full output
// snapshot every cycle; a monitor pops and compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_dest_sel_pipe;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT signals ----------------
  logic [1:0]  sel;
  logic [14:0] cand1;
  logic [23:0] cand2;
  logic        in_valid, stall, flush;
  logic [4:0]  src_a1, src_b1;
  logic [5:0]  src_a2, src_b2;

  logic [14:0] stage_dst1;
  logic [2:0]  stage_vld1, hazard_a_stg1, hazard_b_stg1;
  logic [4:0]  wb_dst1;
  logic        wb_en1, hazard_a1, hazard_b1, sel_err1;

  logic [29:0] stage_dst2;
  logic [4:0]  stage_vld2, hazard_a_stg2, hazard_b_stg2;
  logic [5:0]  wb_dst2;
  logic        wb_en2, hazard_a2, hazard_b2, sel_err2;

  dest_sel_pipe #(
    .WIDTH(5), .NUM_IN(3), .SEL_W(2), .STAGES(3), .FLUSH_STAGES(2), .ZERO_IS_NULL(1'b1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .cand(cand1), .in_valid(in_valid),
    .stall(stall), .flush(flush), .src_a(src_a1), .src_b(src_b1),
    .stage_dst(stage_dst1), .stage_vld(stage_vld1), .wb_dst(wb_dst1), .wb_en(wb_en1),
    .hazard_a(hazard_a1), .hazard_a_stg(hazard_a_stg1),
    .hazard_b(hazard_b1), .hazard_b_stg(hazard_b_stg1), .sel_err(sel_err1)
  );

  dest_sel_pipe #(
    .WIDTH(6), .NUM_IN(4), .SEL_W(2), .STAGES(5), .FLUSH_STAGES(1), .ZERO_IS_NULL(1'b1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .cand(cand2), .in_valid(in_valid),
    .stall(stall), .flush(flush), .src_a(src_a2), .src_b(src_b2),
    .stage_dst(stage_dst2), .stage_vld(stage_vld2), .wb_dst(wb_dst2), .wb_en(wb_en2),
    .hazard_a(hazard_a2), .hazard_a_stg(hazard_a_stg2),
    .hazard_b(hazard_b2), .hazard_b_stg(hazard_b_stg2), .sel_err(sel_err2)
  );

  // ---------------- reference model ----------------
  localparam int P_ST [2] = '{3, 5};
  localparam int P_FS [2] = '{2, 1};
  localparam int P_NI [2] = '{3, 4};
  localparam int P_W  [2] = '{5, 6};

  int m_dst [2][8];
  bit m_vld [2][8];
  bit m_err [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q1[$];
  logic [63:0] exp_q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cand_of(input int inst, input int idx);
    if (inst == 0) return int'(cand1[idx*5 +: 5]);
    return int'(cand2[idx*6 +: 6]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        m_dst[i][k] = 0;
        m_vld[i][k] = 1'b0;
      end
    end
  endtask

  // One clock edge of a pipeline: a list of STAGES slots that moves one
  // place older unless stalled; the youngest FLUSH slots lose their valid.
  task automatic model_step(input int inst);
    int s, c;
    s = int'(sel);
    m_err[inst] = !stall && (s >= P_NI[inst]);
    if (!stall) begin
      for (int k = P_ST[inst] - 1; k > 0; k--) begin
        m_dst[inst][k] = m_dst[inst][k-1];
        m_vld[inst][k] = m_vld[inst][k-1];
      end
      if (s < P_NI[inst]) begin
        c = cand_of(inst, s);
        m_dst[inst][0] = c;
        m_vld[inst][0] = in_valid && (c != 0);
      end else begin
        m_vld[inst][0] = 1'b0;
      end
    end
    if (flush) begin
      for (int k = 0; k < P_FS[inst]; k++) m_vld[inst][k] = 1'b0;
    end
  endtask

  function automatic int youngest_match(input int inst, input int src);
    if (src == 0) return -1;
    for (int k = 0; k < P_ST[inst]; k++) begin
      if (m_vld[inst][k] && (m_dst[inst][k] == src)) return k;
    end
    return -1;
  endfunction

  function automatic logic [63:0] app(input logic [63:0] acc, input int v, input int wd);
    return (acc << wd) | (64'(v) & ((64'd1 << wd) - 64'd1));
  endfunction

  // Packs expected outputs in the same order as the actual snapshot below.
  function automatic logic [63:0] snapshot(input int inst);
    logic [63:0] acc;
    int st, w, ha, hb;
    st  = P_ST[inst];
    w   = P_W[inst];
    ha  = youngest_match(inst, (inst == 0) ? int'(src_a1) : int'(src_a2));
    hb  = youngest_match(inst, (inst == 0) ? int'(src_b1) : int'(src_b2));
    acc = '0;
    for (int k = st - 1; k >= 0; k--) acc = app(acc, m_dst[inst][k], w);
    for (int k = st - 1; k >= 0; k--) acc = app(acc, m_vld[inst][k] ? 1 : 0, 1);
    acc = app(acc, m_err[inst] ? 1 : 0, 1);
    acc = app(acc, (ha >= 0) ? 1 : 0, 1);
    acc = app(acc, (ha >= 0) ? (1 << ha) : 0, st);
    acc = app(acc, (hb >= 0) ? 1 : 0, 1);
    acc = app(acc, (hb >= 0) ? (1 << hb) : 0, st);
    acc = app(acc, m_dst[inst][st-1], w);
    acc = app(acc, m_vld[inst][st-1] ? 1 : 0, 1);
    return acc;
  endfunction

  logic [63:0] act1, act2;
  assign act1 = 64'({stage_dst1, stage_vld1, sel_err1, hazard_a1, hazard_a_stg1,
                     hazard_b1, hazard_b_stg1, wb_dst1, wb_en1});
  assign act2 = 64'({stage_dst2, stage_vld2, sel_err2, hazard_a2, hazard_a_stg2,
                     hazard_b2, hazard_b_stg2, wb_dst2, wb_en2});

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q1.size() > 0) chk("snap_u1", act1, exp_q1.pop_front());
      if (exp_q2.size() > 0) chk("snap_u2", act2, exp_q2.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change at negedge+1; the DUT consumes them at the next posedge,
  // the model follows at posedge+1 and the monitor compares at the negedge.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    exp_q1.push_back(snapshot(0));
    exp_q2.push_back(snapshot(1));
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic iv, input logic st, input logic fl);
    sel      = s;
    in_valid = iv;
    stall    = st;
    flush    = fl;
  endtask

  task automatic load3(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
    drive(s0, 1'b1, 1'b0, 1'b0); cycle();
    drive(s1, 1'b1, 1'b0, 1'b0); cycle();
    drive(s2, 1'b1, 1'b0, 1'b0); cycle();
  endtask

  function automatic logic [5:0] rnd_val(input int w);
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, (1 << w) - 1));
    return 6'($urandom_range(0, 7));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    drive(2'd0, 1'b0, 1'b0, 1'b0);
    cand1 = '0; cand2 = '0;
    src_a1 = '0; src_b1 = '0; src_a2 = '0; src_b2 = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_u1", act1, 64'd0);
    chk("reset_u2", act2, 64'd0);
    rst_n = 1'b1;

    // Sequence: selected candidate appears in stage 0, then at write-back
    cand1 = {5'd31, 5'd12, 5'd7};
    cand2 = {6'd40, 6'd31, 6'd12, 6'd7};
    drive(SEL_RD, 1'b1, 1'b0, 1'b0); cycle();
    chk("seq_dst0", 64'(stage_dst1[4:0]), 64'd12);
    chk("seq_vld0", 64'(stage_vld1[0]), 64'd1);
    chk("sweep_dst0", 64'(stage_dst2[5:0]), 64'd12);
    drive(SEL_RA, 1'b0, 1'b0, 1'b0); cycle(); cycle();
    chk("seq_wb", 64'({wb_dst1, wb_en1}), 64'({5'd12, 1'b1}));

    // Illegal select: bubble and one-cycle error on u1, legal on u2
    drive(2'd3, 1'b1, 1'b0, 1'b0); cycle();
    chk("illegal_err", 64'(sel_err1), 64'd1);
    chk("illegal_vld0", 64'(stage_vld1[0]), 64'd0);
    chk("illegal_dst0_hold", 64'(stage_dst1[4:0]), 64'd31);
    chk("sweep_no_err", 64'(sel_err2), 64'd0);
    chk("sweep_sel3", 64'({stage_dst2[5:0], stage_vld2[0]}), 64'({6'd40, 1'b1}));

    // Zero destination is never valid and never a hazard source
    cand1 = {5'd31, 5'd12, 5'd0};
    cand2 = {6'd40, 6'd31, 6'd12, 6'd0};
    drive(SEL_RT, 1'b1, 1'b0, 1'b0); cycle();
    chk("err_pulse_end", 64'(sel_err1), 64'd0);
    chk("zero_vld0", 64'({stage_dst1[4:0], stage_vld1[0]}), 64'd0);
    chk("zero_src_hazard", 64'(hazard_a1), 64'd0);
    chk("sweep_wb_lat5", 64'({wb_dst2, wb_en2}), 64'({6'd12, 1'b1}));

    // Stall and flush
    cand1 = {5'd9, 5'd12, 5'd7};
    cand2 = {6'd40, 6'd9, 6'd12, 6'd7};
    drive(SEL_RT, 1'b1, 1'b0, 1'b0); cycle();
    chk("bubble_wb", 64'(wb_en1), 64'd0);
    drive(SEL_RD, 1'b1, 1'b0, 1'b0); cycle();
    drive(SEL_RA, 1'b1, 1'b0, 1'b0); cycle();
    chk("filled", 64'({stage_dst1, stage_vld1}), 64'({5'd7, 5'd12, 5'd9, 3'b111}));
    drive(2'd3, 1'b1, 1'b1, 1'b0); cycle(); cycle();
    chk("stall_hold", 64'({stage_dst1, stage_vld1, sel_err1}), 64'({5'd7, 5'd12, 5'd9, 3'b111, 1'b0}));
    drive(SEL_RT, 1'b1, 1'b1, 1'b1); cycle();
    chk("flush_stall_vld", 64'(stage_vld1), 64'(3'b100));
    chk("flush_stall_dst2", 64'(stage_dst1[14:10]), 64'd7);
    chk("sweep_flush_stall", 64'(stage_vld2[0]), 64'd0);
    load3(SEL_RT, SEL_RD, SEL_RA);
    drive(SEL_RT, 1'b1, 1'b0, 1'b1); cycle();
    chk("flush_run_vld", 64'(stage_vld1), 64'(3'b100));
    chk("flush_run_dst2", 64'(stage_dst1[14:10]), 64'd12);
    chk("sweep_flush_run", 64'({stage_dst2[11:6], stage_vld2[1:0]}), 64'({6'd9, 2'b10}));

    // Hazard priority: stage 0 and stage 2 both hold 12
    drive(SEL_RD, 1'b1, 1'b0, 1'b0); cycle();
    drive(SEL_RA, 1'b1, 1'b0, 1'b0); cycle();
    src_a1 = 5'd12; src_b1 = 5'd7; src_a2 = 6'd12; src_b2 = 6'd9;
    drive(SEL_RD, 1'b1, 1'b0, 1'b0); cycle();
    chk("haz_a", 64'({hazard_a1, hazard_a_stg1}), 64'({1'b1, 3'b001}));
    chk("haz_b_none", 64'({hazard_b1, hazard_b_stg1}), 64'd0);
    src_b1 = 5'd12;
    drive(2'd3, 1'b0, 1'b1, 1'b0); cycle();
    chk("haz_both_same", 64'({hazard_a_stg1, hazard_b_stg1}), 64'({3'b001, 3'b001}));

    // Asynchronous reset mid-run with every stage valid
    rst_n = 1'b0;
    #1;
    chk("async_reset_u1", act1, 64'd0);
    chk("async_reset_u2", act2, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      sel      = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 3; i++) cand1[i*5 +: 5] = 5'(rnd_val(5));
      for (int i = 0; i < 4; i++) cand2[i*6 +: 6] = rnd_val(6);
      src_a1 = 5'(rnd_val(5)); src_b1 = 5'(rnd_val(5));
      src_a2 = rnd_val(6);     src_b2 = rnd_val(6);
      cycle();
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q1.size() + exp_q2.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
